// File: rtl/aoi_pkg.sv
// Shared types, constants and golden expression for the AOI sweep checker.
// Imported by the checker RTL and by its testbench.
package aoi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [4:0] LAST_VEC = 5'd31;

  // x[4]=x_in1 ... x[0]=x_in5
  function automatic logic aoi_expected(input logic [4:0] x);
    return ~((x[4] & x[3]) | (x[2] & x[1] & x[0]));
  endfunction

endpackage

// File: rtl/aoi_sweep_checker_golden.sv
// Combinational expected-value block for the 5-input AOI cell.
// Wraps the package function so the checker has one golden source.
module aoi_golden_model
  import aoi_pkg::*;
(
  input  logic [4:0] i_vec,
  output logic       o_y
);

  assign o_y = aoi_expected(i_vec);

endmodule

// File: rtl/aoi_sweep_checker.sv
// Exhaustive sweep of a 5-input AOI cell: drives all 32 vectors,
// waits SETTLE_CYCLES per vector, samples y and tallies mismatches.
module aoi_sweep_checker
  import aoi_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 6
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  output logic [4:0]       o_x_out,
  input  logic             i_y_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [ERR_W-1:0] o_err_count,
  output logic             o_first_err_valid,
  output logic [4:0]       o_first_err_vec
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam bit         NO_SETTLE   = (SETTLE_CYCLES == 0);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e           r_state;
  logic [3:0]       r_settle;
  logic [4:0]       r_x;
  logic             r_busy;
  logic             r_done;
  logic [ERR_W-1:0] r_err;
  logic             r_fe_valid;
  logic [4:0]       r_fe_vec;

  logic w_expected;
  logic w_mismatch;

  aoi_golden_model u_golden (
    .i_vec (r_x),
    .o_y   (w_expected)
  );

  // Case inequality so an X/Z on y_in counts as a failure in simulation.
  assign w_mismatch = (i_y_in !== w_expected);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_settle   <= 4'd0;
      r_x        <= 5'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= '0;
      r_fe_valid <= 1'b0;
      r_fe_vec   <= 5'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_x        <= 5'd0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= '0;
            r_fe_valid <= 1'b0;
            r_fe_vec   <= 5'd0;
            if (NO_SETTLE) begin
              r_state <= SAMPLE;
            end else begin
              r_state  <= SETTLE;
              r_settle <= SETTLE_INIT;
            end
          end
        end
        SETTLE: begin
          r_settle <= r_settle - 4'd1;
          if (r_settle <= 4'd1) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (w_mismatch) begin
            if (r_err != ERR_MAX) begin
              r_err <= r_err + 1'b1;
            end
            if (!r_fe_valid) begin
              r_fe_valid <= 1'b1;
              r_fe_vec   <= r_x;
            end
          end
          if (r_x == LAST_VEC) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_x <= r_x + 5'd1;
            if (!NO_SETTLE) begin
              r_state  <= SETTLE;
              r_settle <= SETTLE_INIT;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_x_out           = r_x;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_err_count       = r_err;
  assign o_first_err_valid = r_fe_valid;
  assign o_first_err_vec   = r_fe_vec;

endmodule

// File: tb/tb_aoi_sweep_checker.sv
// Scoreboard bench: two checkers (S=2/ERR_W=6 and S=0/ERR_W=4)
// against a modelled AOI cell or stuck-at outputs.
module tb_aoi_sweep_checker;
  import aoi_pkg::*;

  typedef struct {
    int e0;
    int lat;
    int err;
    int fv;
    int fe;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  exp_t qa[$];
  exp_t qb[$];

  // instance A: S=2, ERR_W=6
  logic       rst_a, start_a, ya;
  logic [4:0] xa, fe_a;
  logic       busy_a, done_a, fv_a;
  logic [5:0] err_a;
  int         ymode_a = 0;

  // instance B: S=0, ERR_W=4
  logic       rst_b, start_b, yb;
  logic [4:0] xb, fe_b;
  logic       busy_b, done_b, fv_b;
  logic [3:0] err_b;
  int         ymode_b = 0;

  // mode 0: healthy cell, 1: stuck-at-1, 2: stuck-at-0
  assign ya = (ymode_a == 1) ? 1'b1 :
              (ymode_a == 2) ? 1'b0 : aoi_expected(xa);
  assign yb = (ymode_b == 1) ? 1'b1 :
              (ymode_b == 2) ? 1'b0 : aoi_expected(xb);

  aoi_sweep_checker #(
    .SETTLE_CYCLES (2),
    .ERR_W         (6)
  ) u_a (
    .i_clock           (clk),
    .i_reset           (rst_a),
    .i_start           (start_a),
    .o_x_out           (xa),
    .i_y_in            (ya),
    .o_busy            (busy_a),
    .o_done            (done_a),
    .o_err_count       (err_a),
    .o_first_err_valid (fv_a),
    .o_first_err_vec   (fe_a)
  );

  aoi_sweep_checker #(
    .SETTLE_CYCLES (0),
    .ERR_W         (4)
  ) u_b (
    .i_clock           (clk),
    .i_reset           (rst_b),
    .i_start           (start_b),
    .o_x_out           (xb),
    .i_y_in            (yb),
    .o_busy            (busy_b),
    .o_done            (done_b),
    .o_err_count       (err_b),
    .o_first_err_valid (fv_b),
    .o_first_err_vec   (fe_b)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitors: compare on every rising edge of done.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_a === 1'b1 && !prev) begin
        if (qa.size() == 0) begin
          chk("A unexpected done", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("A latency", cyc - e.e0, e.lat);
          chk("A err_count", int'(err_a), e.err);
          chk("A first_err_valid", int'(fv_a), e.fv);
          chk("A first_err_vec", int'(fe_a), e.fe);
          chk("A x_out at done", int'(xa), 31);
          chk("A busy at done", int'(busy_a), 0);
        end
      end
      prev = (done_a === 1'b1);
    end
  end

  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_b === 1'b1 && !prev) begin
        if (qb.size() == 0) begin
          chk("B unexpected done", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("B latency", cyc - e.e0, e.lat);
          chk("B err_count", int'(err_b), e.err);
          chk("B first_err_valid", int'(fv_b), e.fv);
          chk("B first_err_vec", int'(fe_b), e.fe);
          chk("B x_out at done", int'(xb), 31);
          chk("B busy at done", int'(busy_b), 0);
        end
      end
      prev = (done_b === 1'b1);
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, " x_out"}, int'(xa), 0);
    chk({tag, " busy"}, int'(busy_a), 0);
    chk({tag, " done"}, int'(done_a), 0);
    chk({tag, " err_count"}, int'(err_a), 0);
    chk({tag, " first_err_valid"}, int'(fv_a), 0);
    chk({tag, " first_err_vec"}, int'(fe_a), 0);
  endtask

  // Returns at the negedge right after the start edge E0.
  task automatic start_a_sweep(input int mode, input bit exp_done,
                               input int err, input int fv, input int fe);
    exp_t e;
    @(negedge clk);
    ymode_a = mode;
    start_a = 1'b1;
    e = '{e0: cyc + 1, lat: 96, err: err, fv: fv, fe: fe};
    if (exp_done) qa.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic start_b_sweep(input int mode,
                               input int err, input int fv, input int fe);
    exp_t e;
    @(negedge clk);
    ymode_b = mode;
    start_b = 1'b1;
    e = '{e0: cyc + 1, lat: 32, err: err, fv: fv, fe: fe};
    qb.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_a !== 1'b1) chk({tag, " timeout"}, 0, 1);
  endtask

  task automatic wait_done_b(input string tag);
    int n;
    n = 0;
    while (done_b !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_b !== 1'b1) chk({tag, " timeout"}, 0, 1);
  endtask

  initial begin
    int n;
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    #1;
    chk_reset_a("reset");
    chk("B reset err_count", int'(err_b), 0);
    chk("B reset busy", int'(busy_b), 0);
    repeat (2) @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    rst_a   = 1'b0;
    rst_b   = 1'b0;

    // healthy cell, S=2
    start_a_sweep(0, 1'b1, 0, 0, 0);
    chk("A busy after start", int'(busy_a), 1);
    wait_done_a("A clean");

    // stuck-at-1: first miss is vector 7 at E0+24
    start_a_sweep(1, 1'b1, 11, 1, 7);
    repeat (23) @(negedge clk);
    chk("A err before v7", int'(err_a), 0);
    @(negedge clk);
    chk("A err after v7", int'(err_a), 1);
    chk("A fe_vec after v7", int'(fe_a), 7);
    wait_done_a("A stuck1");

    // start in DONE clears and restarts at vector 0
    start_a_sweep(0, 1'b1, 0, 0, 0);
    chk("A restart err_count", int'(err_a), 0);
    chk("A restart first_err_valid", int'(fv_a), 0);
    chk("A restart x_out", int'(xa), 0);
    chk("A restart done", int'(done_a), 0);
    // mid-sweep start must not disturb timing
    repeat (40) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a("A mid-start");

    // asynchronous reset at vector 10
    start_a_sweep(1, 1'b0, 0, 0, 0);
    n = 0;
    while (xa != 5'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("A reached vector 10", int'(xa), 10);
    #2;
    rst_a   = 1'b1;
    start_a = 1'b1;
    #1;
    chk_reset_a("mid reset");
    @(negedge clk);
    rst_a   = 1'b0;
    start_a = 1'b0;
    start_a_sweep(0, 1'b1, 0, 0, 0);
    wait_done_a("A after reset");

    // S=0 instance
    start_b_sweep(2, 15, 1, 0);
    chk("B err at E0", int'(err_b), 0);
    @(negedge clk);
    chk("B err after v0", int'(err_b), 1);
    chk("B x_out after v0", int'(xb), 1);
    wait_done_b("B stuck0");
    start_b_sweep(0, 0, 0, 0);
    wait_done_b("B clean");
    start_b_sweep(1, 11, 1, 7);
    wait_done_b("B stuck1");

    repeat (3) @(negedge clk);
    chk("A queue drained", qa.size(), 0);
    chk("B queue drained", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aoi_sweep_checker.md
# aoi_sweep_checker

Sequential stimulus-and-response stage wrapped around the 5-input AOI cell, y = ~((x1&x2) | (x3&x4&x5)). On a start pulse it drives all 32 input vectors into the cell in ascending order and waits a programmable settle time per vector. It then samples the cell output and compares it against an internal golden expression, counting mismatches and capturing the first failing vector. It sits directly upstream of the AOI cell, driving its inputs, and directly downstream of it, consuming its output, as the self-check stage for that cell.

## Interface
- SETTLE_CYCLES, default 2: cycles a vector is held before its sample cycle; legal range 0..15.
- ERR_W, default 6: width of the mismatch counter; the counter saturates at 2^ERR_W-1.
- clock  in  1  rising-edge clock; the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  sampled high in IDLE or DONE begins a sweep; ignored while busy.
- x_out  out  5  vector to the cell; x_out[4]=x_in1 … x_out[0]=x_in5.
- y_in  in  1  cell output y.
- busy  out  1  high from the start edge until the sweep completes.
- done  out  1  high in DONE; held until the next start or reset.
- err_count  out  ERR_W  number of mismatching vectors, saturating.
- first_err_valid  out  1  at least one mismatch has occurred in this sweep.
- first_err_vec  out  5  vector of the first mismatch; 0 when first_err_valid=0.

## Operation
- States:
  - IDLE, SETTLE, SAMPLE, DONE.
  - Reset enters IDLE with x_out=0, busy=0, done=0, err_count=0, first_err_valid=0, first_err_vec=0, vector counter=0, settle counter=0.
- IDLE/DONE with start=1:
  - clear err_count, first_err_valid and first_err_vec; set x_out=0 and busy=1; clear done.
  - Go to SETTLE with settle counter=SETTLE_CYCLES. When SETTLE_CYCLES=0, go directly to SAMPLE.
- SETTLE: decrement the settle counter each cycle. The cycle in which it reaches 1 transitions to SAMPLE.
- SAMPLE: compare y_in with expected = ~((x_out[4]&x_out[3]) | (x_out[2]&x_out[1]&x_out[0])).
  - A mismatch includes y_in at X or Z (simulation uses case inequality).
  - On mismatch: err_count increments unless it is at all-ones. If first_err_valid=0, load first_err_vec=x_out and set first_err_valid=1.
  - If x_out≠31: x_out increments and the FSM returns to SETTLE, or stays in SAMPLE when SETTLE_CYCLES=0.
  - If x_out=31: go to DONE with busy=0 and done=1. x_out holds at 31.
- start while in SETTLE or SAMPLE has no effect.
- Reset mid-sweep: all outputs take their reset values immediately (asynchronously). The sweep is abandoned; the next start restarts from vector 0.
- start and reset asserted together: reset wins.

## Timing
- Let E0 be the rising edge that samples start. x_out=v is valid from edge E0+v·(S+1), where S=SETTLE_CYCLES.
- Vector v is compared at edge E0+(v+1)·(S+1), and err_count/first_err reflect that compare after that edge.
- done rises and busy falls at edge E0+32·(S+1): 96 cycles for S=2, 32 cycles for S=0. The final compare is included at that same edge.
- The cell is combinational, so y_in must settle within S+1 cycles of an x_out change. Required: S≥0.

## Structure
- Package aoi_pkg holds:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - constant LAST_VEC=5'd31;
  - the AOI expected-value function, also used by the bench.
- One sub-module is natural: aoi_golden_model, a combinational 5-to-1 expected-value block instantiated once in the checker.
- FSM, vector counter, settle counter and error logic stay in aoi_sweep_checker. Target 150–250 lines.

## Test plan
- Correct cell attached, S=2: pulse start → done after 96 cycles; err_count=0; first_err_valid=0; x_out=31.
- y_in tied 1: err_count=11, first_err_vec=5'b00111, first_err_valid=1.
- y_in tied 0, ERR_W=4: 21 raw mismatches saturate to err_count=15; first_err_vec=0.
- Reset asserted while x_out=10: all outputs return to reset values immediately. A new start sweeps 0..31 and completes cleanly (err_count=0 with the correct cell).
- start pulsed mid-sweep is ignored: done time is unchanged. start in DONE clears err_count and restarts from vector 0.
- S=0 with correct cell: done after exactly 32 cycles; err_count=0.
